repeat_word_engine: RTL and testbench
=====================================

# repeat_word_engine

Parametrised byte-stream core sitting between the ice40 UART receiver and transmitter in the io wrapper. Assembles a little-endian word of `DataBytes` bytes from the receive stream, then emits `RepeatCount` derived words on the transmit stream, each serialised little-endian, stepping down by `Step` per repetition. Generalises the fixed one-byte/four-repeat wrapper: configurable width, count and step, back-pressure on both sides, and overrun detection.

## Interface
- `DataBytes`, 1, bytes per input/output word (1..8).
- `RepeatCount`, 4, output words per input word (1..255).
- `Step`, 1, decrement between successive output words (0..255).

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_byte`  in  8  received byte.
- `rx_byte_valid`  in  1  `rx_byte` holds a new byte.
- `rx_byte_done`  out  1  one-cycle pulse: byte consumed.
- `tx_byte`  out  8  byte to transmit.
- `tx_byte_valid`  out  1  `tx_byte` is valid.
- `tx_byte_ready`  in  1  transmitter accepts `tx_byte` this cycle.
- `clear_to_send_out_n`  out  1  low = sender may transmit.
- `overrun`  out  1  sticky: a byte arrived while not in RECV.

## Operation
- Word value x = concatenation of received bytes, first byte in bits [7:0]. W = 8*DataBytes.
- Output word k (k = 0..RepeatCount-1): v_k = (x + (RepeatCount-k)*Step) mod 2^W. Emitted bytes: v_k[7:0] first, v_k[W-1:W-8] last.
- States: RECV (collect bytes), SEND (emit bytes). No other states.
- RECV: on `rx_byte_valid`, store byte at index `byte_idx`, pulse `rx_byte_done` next cycle, increment `byte_idx`. On storing byte DataBytes-1: clear `byte_idx`, `rep_idx`=0, load v_0, go to SEND.
- SEND: `tx_byte_valid`=1, `tx_byte` = byte `byte_idx` of current v. Transfer when valid && ready: advance `byte_idx`; after last byte of a word, subtract Step from v and increment `rep_idx`; after last byte of word RepeatCount-1 return to RECV with `byte_idx`=0.
- `rx_byte_valid` in SEND: byte dropped, `rx_byte_done` still pulsed (receiver must not stall), `overrun` set. Cleared only by `rst`.
- `clear_to_send_out_n` = 1 in SEND, and in RECV in the cycle `rx_byte_valid` completes a word; else 0.
- Step = 0: all RepeatCount words equal x (mod 2^W).
- Arithmetic wraps at W bits; (RepeatCount*Step) computed at W+16 bits then truncated.

## Timing
- Reset values: state RECV, `byte_idx`=0, `rep_idx`=0, `rx_byte_done`=0, `tx_byte`=0, `tx_byte_valid`=0, `clear_to_send_out_n`=0, `overrun`=0.
- `rx_byte_done` asserted exactly the cycle after `rx_byte_valid` is sampled; one cycle wide.
- Latency: last input byte sampled cycle N -> `tx_byte_valid`=1 with v_0[7:0] in cycle N+1.
- `tx_byte` stable while valid && !ready; valid never drops without a transfer, except on `rst`.
- Back-to-back: ready held high -> one byte per cycle; total SEND length = DataBytes*RepeatCount cycles.
- Final transfer cycle M -> RECV in M+1; `clear_to_send_out_n`=0 from M+1; a byte valid in M+1 is accepted.
- `rst` mid-operation: all state to reset values next edge; partial word discarded; pending tx byte abandoned.

## Structure
- Package `repeat_word_pkg`: state enum (RECV, SEND), width helpers (W, index widths `$clog2` of DataBytes and RepeatCount, min 1).
- Sub-module `word_assembler`: byte-to-word shift/index register with completion flag; engine holds FSM, v register, counters.
- Target 150-300 lines total.

## Test plan
- Defaults, rx 0x55 -> tx 0x59, 0x58, 0x57, 0x56 in four consecutive cycles with ready high; `clear_to_send_out_n` high throughout SEND.
- DataBytes=2, RepeatCount=3, Step=0x10, rx 0xF0,0xFF (x=0xFFF0) -> words 0x0020, 0x0010, 0x0000 -> bytes 20,00,10,00,00,00 (wrap check).
- Defaults, ready toggled 1/0 every cycle -> `tx_byte` stable during stalls, same 4 bytes, SEND lasts 8 cycles.
- rx 0x10 then extra byte 0x99 during SEND -> `overrun`=1, 0x99 absent from output, outputs 0x14..0x11, `rx_byte_done` pulsed for both.
- `rst` asserted after second output byte -> next cycle `tx_byte_valid`=0, state RECV, `overrun`=0; fresh rx 0x00 -> 0x04,0x03,0x02,0x01.
- Step=0, RepeatCount=2, rx 0xAB -> 0xAB, 0xAB.

Source files
------------

// File: rtl/repeat_word_pkg.sv
// ---------------------------------------------------------------------------
// repeat_word_pkg
// Shared types and width helpers for the repeat word engine.
//   state_t     : engine states, RECV collects bytes, SEND emits bytes
//   word_width  : bit width of a word built from a number of bytes
//   idx_width   : counter width able to index n items (never below 1 bit)
// ---------------------------------------------------------------------------
package repeat_word_pkg;

  typedef enum logic {
    RECV = 1'b0,
    SEND = 1'b1
  } state_t;

  // Width of a word assembled from data_bytes bytes.
  function automatic int word_width(input int data_bytes);
    return 8 * data_bytes;
  endfunction

  // Index counter width; a single-entry range still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// Collects a little-endian word of DataBytes bytes, first byte in [7:0].
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   enable      : bytes are only stored while high
//   byte_in     : incoming byte
//   byte_valid  : byte_in holds a new byte this cycle
//   word_out    : stored bytes with the incoming byte merged at its slot
//   word_done   : the byte presented this cycle completes the word
// ---------------------------------------------------------------------------
module word_assembler
  import repeat_word_pkg::*;
#(
  parameter int DataBytes = 1,
  localparam int W = word_width(DataBytes),
  localparam int BIW = idx_width(DataBytes)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic [W-1:0] word_out,
  output logic         word_done
);

  localparam logic [BIW-1:0] LAST_IDX = BIW'(DataBytes - 1);

  logic [BIW-1:0] idx;
  logic [W-1:0]   word_q;
  logic [BIW+2:0] bit_pos;
  logic           last_byte;

  // The completed word is presented combinationally so the engine can load
  // its first output value in the same cycle the final byte is sampled.
  always_comb begin
    last_byte = (idx == LAST_IDX);
    bit_pos   = {idx, 3'b000};
    word_out  = (word_q & ~(W'(8'hFF) << bit_pos)) | (W'(byte_in) << bit_pos);
    word_done = enable && byte_valid && last_byte;
  end

  // The partial word is cleared once complete so unfilled slots are zero
  // when the next word starts arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      word_q <= '0;
    end else if (enable && byte_valid) begin
      if (last_byte) begin
        idx    <= '0;
        word_q <= '0;
      end else begin
        idx    <= idx + 1'b1;
        word_q <= word_out;
      end
    end
  end

endmodule

// File: rtl/repeat_word_engine.sv
// ---------------------------------------------------------------------------
// repeat_word_engine
// Builds a word x from the receive byte stream, then transmits RepeatCount
// words v_k = x + (RepeatCount-k)*Step (mod 2^W), each little-endian.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   rx_byte/rx_byte_valid : receive byte stream
//   rx_byte_done          : one-cycle pulse the cycle after a byte is taken
//   tx_byte/tx_byte_valid : transmit byte stream
//   tx_byte_ready         : transmitter accepts tx_byte this cycle
//   clear_to_send_out_n   : low when the sender may transmit
//   overrun               : sticky, a byte arrived while sending
// ---------------------------------------------------------------------------
module repeat_word_engine
  import repeat_word_pkg::*;
#(
  parameter int DataBytes   = 1,
  parameter int RepeatCount = 4,
  parameter int Step        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  output logic       rx_byte_done,
  output logic [7:0] tx_byte,
  output logic       tx_byte_valid,
  input  logic       tx_byte_ready,
  output logic       clear_to_send_out_n,
  output logic       overrun
);

  localparam int W   = word_width(DataBytes);
  localparam int BIW = idx_width(DataBytes);
  localparam int RIW = idx_width(RepeatCount);

  // The offset of the first word is formed wide and then truncated so a
  // large count times step wraps exactly like the per-word arithmetic.
  localparam logic [W+15:0]  TOTAL_STEP   = (W+16)'(RepeatCount) * (W+16)'(Step);
  localparam logic [W-1:0]   FIRST_OFFSET = TOTAL_STEP[W-1:0];
  localparam logic [W-1:0]   STEP_W       = W'(Step);
  localparam logic [BIW-1:0] LAST_BYTE    = BIW'(DataBytes - 1);
  localparam logic [RIW-1:0] LAST_REP     = RIW'(RepeatCount - 1);

  state_t         state;
  logic [W-1:0]   v;
  logic [BIW-1:0] byte_idx;
  logic [RIW-1:0] rep_idx;
  logic [W-1:0]   word;
  logic           word_done;
  logic [W-1:0]   first_v;
  logic [W-1:0]   next_v;
  logic           tx_fire;

  function automatic logic [7:0] byte_of(input logic [W-1:0] w, input logic [BIW-1:0] i);
    logic [W-1:0] shifted;
    shifted = w >> {i, 3'b000};
    return shifted[7:0];
  endfunction

  word_assembler #(
    .DataBytes(DataBytes)
  ) u_assembler (
    .clk       (clk),
    .rst       (rst),
    .enable    (state == RECV),
    .byte_in   (rx_byte),
    .byte_valid(rx_byte_valid),
    .word_out  (word),
    .word_done (word_done)
  );

  // Next values of the working word and the transfer handshake.
  assign first_v = word + FIRST_OFFSET;
  assign next_v  = v - STEP_W;
  assign tx_fire = tx_byte_valid && tx_byte_ready;

  // The sender is held off for the whole send phase and already in the
  // cycle that completes a word, so no byte lands in the gap.
  assign clear_to_send_out_n = (state == SEND) || word_done;

  // Main FSM. tx_byte is always registered one step ahead: whenever a byte
  // is transferred the following byte (or the next word's low byte) is
  // loaded, which keeps tx_byte steady while the transmitter stalls.
  // Bytes arriving during SEND are acknowledged but dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RECV;
      v             <= '0;
      byte_idx      <= '0;
      rep_idx       <= '0;
      rx_byte_done  <= 1'b0;
      tx_byte       <= '0;
      tx_byte_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_byte_done <= rx_byte_valid;
      case (state)
        RECV: begin
          if (word_done) begin
            v             <= first_v;
            byte_idx      <= '0;
            rep_idx       <= '0;
            tx_byte       <= first_v[7:0];
            tx_byte_valid <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (rx_byte_valid) begin
            overrun <= 1'b1;
          end
          if (tx_fire) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              tx_byte  <= byte_of(v, byte_idx + 1'b1);
            end else if (rep_idx != LAST_REP) begin
              byte_idx <= '0;
              rep_idx  <= rep_idx + 1'b1;
              v        <= next_v;
              tx_byte  <= next_v[7:0];
            end else begin
              byte_idx      <= '0;
              rep_idx       <= '0;
              tx_byte       <= '0;
              tx_byte_valid <= 1'b0;
              state         <= RECV;
            end
          end
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_repeat_word_engine.sv
// ---------------------------------------------------------------------------
// tb_repeat_word_engine
// Three engine instances with different configurations share stimulus
// signals; only one is exercised at a time. Expected transmit bytes are
// computed from the word formula and queued; a monitor on the falling edge
// pops and compares every transferred byte.
// ---------------------------------------------------------------------------
module tb_repeat_word_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [7:0]       rx_byte;
  logic [2:0]       rx_valid;
  logic             tx_ready;
  logic [2:0]       rx_done;
  logic [2:0]       tx_valid;
  logic [2:0]       cts;
  logic [2:0]       overrun;
  logic [2:0][7:0]  tx_byte;

  int               checks = 0;
  int               errors = 0;
  logic [15:0]      exp_q[$];
  bit   [2:0]       ov_exp = '0;
  logic [2:0]       prev_stall = '0;
  logic [7:0]       prev_byte [3];

  repeat_word_engine #(.DataBytes(1), .RepeatCount(4), .Step(1)) u_dflt (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_valid[0]),
    .rx_byte_done(rx_done[0]), .tx_byte(tx_byte[0]), .tx_byte_valid(tx_valid[0]),
    .tx_byte_ready(tx_ready), .clear_to_send_out_n(cts[0]), .overrun(overrun[0])
  );

  repeat_word_engine #(.DataBytes(2), .RepeatCount(3), .Step(16)) u_wide (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_valid[1]),
    .rx_byte_done(rx_done[1]), .tx_byte(tx_byte[1]), .tx_byte_valid(tx_valid[1]),
    .tx_byte_ready(tx_ready), .clear_to_send_out_n(cts[1]), .overrun(overrun[1])
  );

  repeat_word_engine #(.DataBytes(1), .RepeatCount(2), .Step(0)) u_flat (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_byte_valid(rx_valid[2]),
    .rx_byte_done(rx_done[2]), .tx_byte(tx_byte[2]), .tx_byte_valid(tx_valid[2]),
    .tx_byte_ready(tx_ready), .clear_to_send_out_n(cts[2]), .overrun(overrun[2])
  );

  // Parameters of each instance, mirrored for the reference model.
  function automatic void getCfg(input int id, output int db, output int rc, output int st);
    case (id)
      0:       begin db = 1; rc = 4; st = 1;  end
      1:       begin db = 2; rc = 3; st = 16; end
      default: begin db = 1; rc = 2; st = 0;  end
    endcase
  endfunction

  // Reference model: queue every byte the instance should transmit for x.
  function automatic void pushExpected(input int id, input logic [63:0] x);
    int db, rc, st;
    logic [63:0] mask, v;
    getCfg(id, db, rc, st);
    mask = (db == 8) ? '1 : ((64'd1 << (8 * db)) - 64'd1);
    for (int k = 0; k < rc; k++) begin
      v = (x + 64'(rc - k) * 64'(st)) & mask;
      for (int b = 0; b < db; b++) begin
        exp_q.push_back({8'(id), 8'(v >> (8 * b))});
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Feeds one word byte by byte, checking the done pulse, the clear-to-send
  // hold on the completing byte and the one-cycle output latency. The
  // ready level for the first send cycle is set according to mode
  // (0 always ready, 1 toggling starting low, 2 random).
  task automatic applyStimulus(input int id, input logic [63:0] x, input int mode);
    int db, rc, st;
    getCfg(id, db, rc, st);
    pushExpected(id, x);
    for (int b = 0; b < db; b++) begin
      @(posedge clk); #1;
      rx_byte      = 8'(x >> (8 * b));
      rx_valid[id] = 1'b1;
      #1;
      checkOutput("cts_on_rx", cts[id], 64'(b == db - 1));
      @(posedge clk); #1;
      rx_valid[id] = 1'b0;
      checkOutput("rx_done", rx_done[id], 1);
      checkOutput("tx_latency", tx_valid[id], 64'(b == db - 1));
    end
    tx_ready = (mode == 1) ? 1'b0 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // Runs the send phase to completion, optionally injecting a stray byte,
  // then checks its length, the idle clear-to-send level and overrun.
  task automatic waitIdle(input int id, input int mode, input bit inject, input int exp_len);
    int cycles;
    bit finished;
    cycles   = 0;
    finished = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      checkOutput("rx_done_pulse", rx_done[id], 64'((t == 0) || (inject && t == 2)));
      if (!tx_valid[id]) begin
        finished = 1;
        break;
      end
      cycles++;
      @(posedge clk); #1;
      rx_byte      = 8'h99;
      rx_valid[id] = inject && (t == 0);
      if (inject && t == 0) ov_exp[id] = 1'b1;
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
    checkOutput("send_timeout", 64'(finished), 1);
    if (exp_len >= 0) checkOutput("send_len", 64'(cycles), 64'(exp_len));
    checkOutput("cts_idle", cts[id], 0);
    checkOutput("overrun", overrun[id], 64'(ov_exp[id]));
  endtask

  // Monitor: every transferred byte is matched against the queue, the
  // sender stays blocked while sending, and stalled bytes stay put.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (tx_valid[i]) begin
          checkOutput("cts_send", cts[i], 1);
          if (prev_stall[i]) checkOutput("tx_stable", tx_byte[i], prev_byte[i]);
          if (tx_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL tx_unexpected: got 0x%0h from instance %0d, want nothing", tx_byte[i], i);
            end else begin
              checkOutput("tx_byte", {8'(i), tx_byte[i]}, exp_q.pop_front());
            end
          end
          prev_stall[i] <= !tx_ready;
          prev_byte[i]  <= tx_byte[i];
        end else begin
          if (prev_stall[i]) checkOutput("valid_held", tx_valid[i], 1);
          prev_stall[i] <= 1'b0;
        end
      end
    end
  end

  initial begin
    int db, rc, st, id, mode;
    bit inj;
    logic [63:0] x;

    rst      = 1'b1;
    rx_byte  = '0;
    rx_valid = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_tx_valid", tx_valid[i], 0);
      checkOutput("rst_tx_byte", tx_byte[i], 0);
      checkOutput("rst_rx_done", rx_done[i], 0);
      checkOutput("rst_cts", cts[i], 0);
      checkOutput("rst_overrun", overrun[i], 0);
    end
    rst = 1'b0;

    $display("[TB] defaults, back-to-back, toggled ready, overrun");
    applyStimulus(0, 64'h55, 0);
    waitIdle(0, 0, 0, 4);
    applyStimulus(0, 64'h55, 1);
    waitIdle(0, 1, 0, 8);
    applyStimulus(0, 64'h10, 0);
    waitIdle(0, 0, 1, 4);

    $display("[TB] reset during send");
    applyStimulus(0, 64'h20, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_tx_valid", tx_valid[0], 0);
    checkOutput("midrst_tx_byte", tx_byte[0], 0);
    checkOutput("midrst_cts", cts[0], 0);
    checkOutput("midrst_overrun", overrun[0], 0);
    checkOutput("midrst_pending", 64'(exp_q.size()), 2);
    exp_q.delete();
    ov_exp = '0;
    @(posedge clk); #1;
    rst      = 1'b0;
    tx_ready = 1'b1;
    applyStimulus(0, 64'h00, 0);
    waitIdle(0, 0, 0, 4);

    $display("[TB] two-byte wrap and zero step");
    applyStimulus(1, 64'hFFF0, 0);
    waitIdle(1, 0, 0, 6);
    applyStimulus(2, 64'hAB, 0);
    waitIdle(2, 0, 0, 2);

    $display("[TB] random words");
    for (int n = 0; n < 30; n++) begin
      id   = $urandom_range(0, 2);
      mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      inj  = ($urandom_range(0, 3) == 0);
      x    = {$urandom, $urandom};
      getCfg(id, db, rc, st);
      applyStimulus(id, x, mode);
      waitIdle(id, mode, inj, (mode == 0) ? db * rc : -1);
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue_drained", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
